// File: rtl/sudoku_pkg.sv
// Shared types and helpers for the Sudoku group checking blocks.
package sudoku_pkg;

  // Default group size: one row, column or box of a 9x9 grid.
  localparam int unsigned GRID_N = 9;

  // Group checker phases: gathering cells, then holding one result.
  typedef enum logic {
    COLLECT = 1'b0,
    RESULT  = 1'b1
  } group_state_e;

  // Bits needed to hold a cell value 0..n (0 = empty).
  function automatic int unsigned val_w(int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/group_onehot_checker_cell_decode.sv
// Combinational decode of one cell value into a onehot digit plus
// empty / out-of-range flags. Out-of-range values give an all-zero onehot.
module cell_decode #(
  parameter int unsigned N     = 9,
  parameter int unsigned VAL_W = $clog2(N + 1)
) (
  input  logic [VAL_W-1:0] value,
  output logic [N-1:0]     onehot,
  output logic             is_empty,
  output logic             is_range_err
);

  // Bit k lights up for digit k+1.
  always_comb begin
    onehot = '0;
    for (int unsigned k = 0; k < N; k++) begin
      onehot[k] = (value == VAL_W'(k + 1));
    end
  end

  assign is_empty     = (value == '0);
  assign is_range_err = (value > VAL_W'(N));

endmodule

// File: rtl/group_onehot_checker.sv
// Streaming Sudoku group checker: takes N cells one per beat, accumulates a
// onehot occupancy mask with duplicate / range / empty tracking, then holds one
// registered result until the consumer takes it.
module group_onehot_checker
  import sudoku_pkg::*;
#(
  parameter int unsigned N     = GRID_N,
  parameter int unsigned VAL_W = val_w(N),
  parameter int unsigned CNT_W = val_w(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VAL_W-1:0] in_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_mask,
  output logic [N-1:0]     out_cand,
  output logic             out_all_set,
  output logic             out_dup,
  output logic [VAL_W-1:0] out_dup_value,
  output logic             out_range_err,
  output logic [CNT_W-1:0] out_empty_cnt
);

  group_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     mask_q, mask_d;
  logic [N-1:0]     cand_q, cand_d;
  logic             all_set_q, all_set_d;
  logic             dup_q, dup_d;
  logic [VAL_W-1:0] dup_value_q, dup_value_d;
  logic             range_err_q, range_err_d;
  logic [CNT_W-1:0] empty_cnt_q, empty_cnt_d;

  logic [N-1:0] onehot;
  logic         is_empty;
  logic         is_range_err;
  logic         last_beat;

  cell_decode #(
    .N     (N),
    .VAL_W (VAL_W)
  ) u_cell_decode (
    .value        (in_value),
    .onehot       (onehot),
    .is_empty     (is_empty),
    .is_range_err (is_range_err)
  );

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == RESULT);
  assign last_beat = (cnt_q == CNT_W'(N - 1));

  // Next-state: accumulate accepted beats, latch the result on the Nth, and
  // wipe everything on handshake or clear (clear wins over all else).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mask_d      = mask_q;
    cand_d      = cand_q;
    all_set_d   = all_set_q;
    dup_d       = dup_q;
    dup_value_d = dup_value_q;
    range_err_d = range_err_q;
    empty_cnt_d = empty_cnt_q;

    case (state_q)
      COLLECT: begin
        if (in_valid) begin
          if (is_empty) begin
            empty_cnt_d = empty_cnt_q + CNT_W'(1);
          end else if (is_range_err) begin
            range_err_d = 1'b1;
          end else if (|(onehot & mask_q)) begin
            dup_d = 1'b1;
            // Keep the first repeat seen in arrival order.
            if (dup_value_q == '0) dup_value_d = in_value;
          end else begin
            mask_d = mask_q | onehot;
          end

          if (last_beat) begin
            // Counter holds at N-1 until the group is retired.
            state_d   = RESULT;
            cand_d    = ~mask_d;
            all_set_d = (&mask_d) & ~dup_d & ~range_err_d;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase

    if (clear || ((state_q == RESULT) && out_ready)) begin
      state_d     = COLLECT;
      cnt_d       = '0;
      mask_d      = '0;
      cand_d      = '0;
      all_set_d   = 1'b0;
      dup_d       = 1'b0;
      dup_value_d = '0;
      range_err_d = 1'b0;
      empty_cnt_d = '0;
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      mask_q      <= '0;
      cand_q      <= '0;
      all_set_q   <= 1'b0;
      dup_q       <= 1'b0;
      dup_value_q <= '0;
      range_err_q <= 1'b0;
      empty_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      cand_q      <= cand_d;
      all_set_q   <= all_set_d;
      dup_q       <= dup_d;
      dup_value_q <= dup_value_d;
      range_err_q <= range_err_d;
      empty_cnt_q <= empty_cnt_d;
    end
  end

  assign out_mask      = mask_q;
  assign out_cand      = cand_q;
  assign out_all_set   = all_set_q;
  assign out_dup       = dup_q;
  assign out_dup_value = dup_value_q;
  assign out_range_err = range_err_q;
  assign out_empty_cnt = empty_cnt_q;

endmodule

// File: tb/tb_group_onehot_checker.sv
// Bench for group_onehot_checker: N=9, N=16 and N=4 instances sharing clock,
// reset, clear, out_ready and the value bus; each has its own in_valid.
module tb_group_onehot_checker;

  typedef struct {
    int mask;
    int cand;
    int all_set;
    int dup;
    int dupv;
    int rng;
    int empty;
  } res_t;

  typedef struct {
    int   v[9];
    res_t e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       out_ready;
  logic [4:0] in_value;

  logic       iv9, ir9, ov9, as9, d9, r9;
  logic [8:0] m9, c9;
  logic [3:0] dv9, e9;

  logic        iv16, ir16, ov16, as16, d16, r16;
  logic [15:0] m16, c16;
  logic [4:0]  dv16, e16;

  logic       iv4, ir4, ov4, as4, d4, r4;
  logic [3:0] m4, c4;
  logic [2:0] dv4, e4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  group_onehot_checker #(.N(9)) u_dut9 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(iv9), .in_ready(ir9),
    .in_value(in_value[3:0]), .out_valid(ov9), .out_ready(out_ready), .out_mask(m9),
    .out_cand(c9), .out_all_set(as9), .out_dup(d9), .out_dup_value(dv9),
    .out_range_err(r9), .out_empty_cnt(e9)
  );

  group_onehot_checker #(.N(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(iv16), .in_ready(ir16),
    .in_value(in_value), .out_valid(ov16), .out_ready(out_ready), .out_mask(m16),
    .out_cand(c16), .out_all_set(as16), .out_dup(d16), .out_dup_value(dv16),
    .out_range_err(r16), .out_empty_cnt(e16)
  );

  group_onehot_checker #(.N(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(iv4), .in_ready(ir4),
    .in_value(in_value[2:0]), .out_valid(ov4), .out_ready(out_ready), .out_mask(m4),
    .out_cand(c4), .out_all_set(as4), .out_dup(d4), .out_dup_value(dv4),
    .out_range_err(r4), .out_empty_cnt(e4)
  );

  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int n_of(int sel);
    return (sel == 0) ? 9 : (sel == 1) ? 16 : 4;
  endfunction

  task automatic set_iv(int sel, logic b);
    case (sel)
      0:       iv9  = b;
      1:       iv16 = b;
      default: iv4  = b;
    endcase
  endtask

  function automatic logic iready(int sel);
    return (sel == 0) ? ir9 : (sel == 1) ? ir16 : ir4;
  endfunction

  function automatic logic ovalid(int sel);
    return (sel == 0) ? ov9 : (sel == 1) ? ov16 : ov4;
  endfunction

  function automatic res_t get_out(int sel);
    res_t r;
    case (sel)
      0:       r = '{int'(m9), int'(c9), int'(as9), int'(d9), int'(dv9), int'(r9), int'(e9)};
      1:       r = '{int'(m16), int'(c16), int'(as16), int'(d16), int'(dv16), int'(r16),
                     int'(e16)};
      default: r = '{int'(m4), int'(c4), int'(as4), int'(d4), int'(dv4), int'(r4), int'(e4)};
    endcase
    return r;
  endfunction

  // Reference: count occurrences of each digit, then derive every output.
  function automatic res_t model(int vals[16], int n);
    int   seen[32];
    res_t r;
    r = '{0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 32; i++) seen[i] = 0;
    for (int i = 0; i < n; i++) begin
      if (vals[i] == 0) r.empty++;
      else if (vals[i] > n) r.rng = 1;
      else begin
        if (seen[vals[i]] > 0) begin
          r.dup = 1;
          if (r.dupv == 0) r.dupv = vals[i];
        end
        seen[vals[i]]++;
      end
    end
    for (int k = 1; k <= n; k++) if (seen[k] > 0) r.mask += (1 << (k - 1));
    r.cand    = ((1 << n) - 1) - r.mask;
    r.all_set = (r.mask == (1 << n) - 1 && r.dup == 0 && r.rng == 0) ? 1 : 0;
    return r;
  endfunction

  task automatic drive_beat(int sel, int v);
    int g = 0;
    in_value = 5'(v);
    set_iv(sel, 1'b1);
    while (!iready(sel) && g < 50) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (g >= 50) chk("beat_timeout", 0, 1);
    @(posedge clk);
    #1;
    set_iv(sel, 1'b0);
  endtask

  task automatic send_group(int sel, int vals[16], int n);
    for (int i = 0; i < n; i++) drive_beat(sel, vals[i]);
  endtask

  task automatic check_result(int sel, string nm, res_t e);
    res_t a;
    a = get_out(sel);
    chk({nm, ".valid"}, int'(ovalid(sel)), 1);
    chk({nm, ".mask"}, a.mask, e.mask);
    chk({nm, ".cand"}, a.cand, e.cand);
    chk({nm, ".all_set"}, a.all_set, e.all_set);
    chk({nm, ".dup"}, a.dup, e.dup);
    chk({nm, ".dup_value"}, a.dupv, e.dupv);
    chk({nm, ".range_err"}, a.rng, e.rng);
    chk({nm, ".empty_cnt"}, a.empty, e.empty);
  endtask

  task automatic handshake(int sel, string nm);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({nm, ".hs_valid"}, int'(ovalid(sel)), 0);
    chk({nm, ".hs_ready"}, int'(iready(sel)), 1);
  endtask

  // Full group: stream, check latency, optional backpressure, check, retire.
  task automatic run_group(int sel, string nm, int vals[16], int waitcyc);
    res_t e;
    e = model(vals, n_of(sel));
    send_group(sel, vals, n_of(sel));
    chk({nm, ".latency"}, int'(ovalid(sel)), 1);
    for (int w = 0; w < waitcyc; w++) begin
      @(posedge clk);
      #1;
      chk({nm, ".held_ready"}, int'(iready(sel)), 0);
    end
    check_result(sel, nm, e);
    handshake(sel, nm);
  endtask

  function automatic void random_group(int sel, output int vals[16]);
    int n = n_of(sel);
    int maxv = (sel == 0) ? 15 : (sel == 1) ? 31 : 7;
    for (int i = 0; i < 16; i++) vals[i] = 0;
    if ($urandom_range(0, 3) == 0) begin
      for (int i = 0; i < n; i++) vals[i] = i + 1;
      for (int i = n - 1; i > 0; i--) begin
        int j = $urandom_range(0, i);
        int t = vals[i];
        vals[i] = vals[j];
        vals[j] = t;
      end
    end else begin
      for (int i = 0; i < n; i++) begin
        int k = $urandom_range(0, 19);
        if (k < 2) vals[i] = $urandom_range(n + 1, maxv);
        else if (k < 5) vals[i] = 0;
        else vals[i] = $urandom_range(1, n);
      end
    end
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    int   vals[16];
    res_t e;

    tbl[0].v = '{5, 3, 0, 0, 7, 0, 0, 0, 0};
    tbl[0].e = '{'h054, 'h1AB, 0, 0, 0, 0, 6};
    tbl[1].v = '{2, 4, 6, 8, 1, 3, 5, 7, 9};
    tbl[1].e = '{'h1FF, 'h000, 1, 0, 0, 0, 0};
    tbl[2].v = '{4, 2, 4, 2, 0, 0, 0, 0, 0};
    tbl[2].e = '{'h00A, 'h1F5, 0, 1, 4, 0, 5};
    tbl[3].v = '{3, 5, 5, 3, 1, 2, 4, 6, 7};
    tbl[3].e = '{'h07F, 'h180, 0, 1, 5, 0, 0};
    tbl[4].v = '{1, 2, 3, 4, 5, 6, 7, 8, 15};
    tbl[4].e = '{'h0FF, 'h100, 0, 0, 0, 1, 0};
    tbl[5].v = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[5].e = '{'h000, 'h1FF, 0, 0, 0, 0, 9};
    tbl[6].v = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
    tbl[6].e = '{'h1FF, 'h000, 1, 0, 0, 0, 0};

    rst_n = 1'b0; clear = 1'b0; out_ready = 1'b0; in_value = '0;
    iv9 = 1'b0; iv16 = 1'b0; iv4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.valid", int'(ov9), 0);
    chk("reset.mask", int'(m9), 0);
    chk("reset.cand", int'(c9), 0);
    chk("reset.empty", int'(e9), 0);
    chk("reset.dup_value", int'(dv9), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset.ready", int'(ir9), 1);

    // Table vectors; out_ready held high so the result retires next edge.
    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < 16; i++) vals[i] = (i < 9) ? tbl[t].v[i] : 0;
      out_ready = 1'b1;
      send_group(0, vals, 9);
      chk($sformatf("tbl%0d.latency", t), int'(ov9), 1);
      check_result(0, $sformatf("tbl%0d", t), tbl[t].e);
      handshake(0, $sformatf("tbl%0d", t));
    end

    // Backpressure: result holds while in_valid is offered and refused.
    vals = '{1, 2, 12, 3, 4, 5, 6, 7, 8, 0, 0, 0, 0, 0, 0, 0};
    send_group(0, vals, 9);
    in_value = 5'd9;
    iv9 = 1'b1;
    for (int w = 0; w < 5; w++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d.ready", w), int'(ir9), 0);
      chk($sformatf("bp%0d.mask", w), int'(m9), 'h0FF);
    end
    iv9 = 1'b0;
    check_result(0, "bp", '{'h0FF, 'h100, 0, 0, 0, 1, 0});
    handshake(0, "bp");
    vals = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 0, 0, 0, 0, 0, 0};
    run_group(0, "bp_next", vals, 0);

    // Clear after four dirty beats, then a clean group.
    drive_beat(0, 1); drive_beat(0, 1); drive_beat(0, 0); drive_beat(0, 12);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk("clr_mid.empty", int'(e9), 0);
    run_group(0, "clr_mid_next", vals, 0);

    // Clear coinciding with the final beat drops the group.
    for (int i = 0; i < 8; i++) drive_beat(0, 0);
    in_value = 5'd9; iv9 = 1'b1; clear = 1'b1;
    @(posedge clk);
    #1;
    iv9 = 1'b0; clear = 1'b0;
    chk("clr_last.valid", int'(ov9), 0);
    chk("clr_last.ready", int'(ir9), 1);
    run_group(0, "clr_last_next", vals, 0);

    // Clear while holding a result (no handshake).
    send_group(0, vals, 9);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk("clr_res.valid", int'(ov9), 0);
    chk("clr_res.ready", int'(ir9), 1);
    chk("clr_res.mask", int'(m9), 0);

    // Randomised groups against the model.
    for (int sel = 0; sel < 3; sel++) begin
      for (int g = 0; g < ((sel == 0) ? 30 : 10); g++) begin
        random_group(sel, vals);
        run_group(sel, $sformatf("rnd%0d_%0d", n_of(sel), g), vals, $urandom_range(0, 3));
      end
    end

    // N=16 and N=4: complete sets and an N+1 value.
    for (int i = 0; i < 16; i++) vals[i] = 16 - i;
    run_group(1, "n16_full", vals, 0);
    vals[5] = 17;
    run_group(1, "n16_range", vals, 1);
    vals = '{3, 1, 4, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_group(2, "n4_full", vals, 0);
    vals[2] = 5;
    run_group(2, "n4_range", vals, 0);

    // Asynchronous reset mid-group on N=16.
    drive_beat(1, 0); drive_beat(1, 3); drive_beat(1, 0); drive_beat(1, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.valid", int'(ov16), 0);
    chk("arst.mask", int'(m16), 0);
    chk("arst.empty", int'(e16), 0);
    chk("arst.dup", int'(d16), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst.ready", int'(ir16), 1);
    chk("arst.valid_after", int'(ov16), 0);
    for (int i = 0; i < 16; i++) vals[i] = i + 1;
    run_group(1, "arst_next", vals, 0);

    // Asynchronous reset while a result is pending on N=9.
    vals = '{5, 3, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    send_group(0, vals, 9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_res.valid", int'(ov9), 0);
    chk("arst_res.cand", int'(c9), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_res.ready", int'(ir9), 1);
    e = model(vals, 9);
    send_group(0, vals, 9);
    check_result(0, "arst_res_next", e);
    handshake(0, "arst_res_next");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/group_onehot_checker.md
Name: group_onehot_checker

Overview:
- Streaming, parametrised successor to the combinational value-to-onehot conversion.
- Accepts the N cells of one Sudoku group (row, column or box) one cell per beat over a valid/ready handshake.
- Accumulates a onehot occupancy mask, detects duplicates, out-of-range values and empty cells, then presents one registered result per group on a valid/ready output.
- Sits between the grid-scan sequencer and the candidate/constraint logic.

Parameters:
- N, 9, group size (number of cells and number of legal values); legal values are 4, 9 and 16.
- VAL_W, $clog2(N+1), width of one cell value; 0 encodes an empty cell.
- CNT_W, $clog2(N+1), width of the beat counter and the empty-cell count.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- clear  in  1  synchronous abort; drops any partial group or pending result.
- in_valid  in  1  cell value valid.
- in_ready  out  1  block can accept a cell.
- in_value  in  VAL_W  cell value; 0 = empty, 1..N = digit.
- out_valid  out  1  group result valid.
- out_ready  in  1  consumer accepts the result.
- out_mask  out  N  bit k set = value k+1 present in the group.
- out_cand  out  N  ~out_mask, the values still missing.
- out_all_set  out  1  out_mask all ones, with no duplicate and no range error.
- out_dup  out  1  at least one nonzero value occurred twice or more.
- out_dup_value  out  VAL_W  first duplicated value in arrival order; 0 if none.
- out_range_err  out  1  at least one value > N was received.
- out_empty_cnt  out  CNT_W  number of 0-valued cells in the group.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = COLLECT; beat count = 0; mask = 0.
  - dup, dup_value, range_err and empty_cnt = 0.
  - out_valid = 0; in_ready = 1 once reset is released. All out_* data ports are 0.
- FSM has two states, COLLECT and RESULT.
- COLLECT:
  - in_ready = 1. A beat is accepted on in_valid & in_ready.
  - in_value == 0: empty_cnt increments.
  - in_value in 1..N, bit (in_value-1) already set: dup set sticky; dup_value captured only if it is currently 0.
  - in_value in 1..N, bit not set: that bit of mask is set.
  - in_value > N: range_err set sticky; mask is unchanged.
  - The beat counter increments on each accepted beat. On accepting beat N-1 (the Nth beat), the next state is RESULT.
- RESULT:
  - in_ready = 0 and out_valid = 1. All out_* ports are registered and hold stable until the handshake completes.
  - On out_valid & out_ready, go to COLLECT next cycle. Counter, mask and all flags are cleared on that same edge.
  - No overlap of groups: in_ready stays 0 for the whole of RESULT, including the handshake cycle.
- Latency: out_valid rises on the cycle after the Nth beat is accepted. Minimum throughput is one group per N+1 cycles.
- clear:
  - Takes priority over every other event in the same cycle, including an accepted final beat or an output handshake.
  - Next state is COLLECT with everything cleared. out_valid falls the following cycle.
- in_valid while in RESULT: ignored, not consumed. The upstream holds the beat.
- out_ready asserted while in COLLECT: no effect.
- Reset asserted mid-group or mid-result: immediate return to the reset values. The partial group is lost.
- The counter never wraps mid-group; it runs 0..N-1 and then holds until cleared by the handshake or clear.
- All compares are unsigned at VAL_W. For N=16, VAL_W=5, so 17..31 are out of range.

Decomposition:
- Shared package sudoku_pkg holds:
  - the GRID_N default (9);
  - the group_state_e enum (COLLECT, RESULT);
  - the helper function val_w(n) = $clog2(n+1).
- One sub-module, cell_decode, parameterised by N and purely combinational:
  - input: value;
  - outputs: onehot bit vector (N), is_empty, is_range_err.
- The top level holds the FSM, counter, accumulation and output registers.

Test Plan:
- N=9, stream 5,3,0,0,7,0,0,0,0 with out_ready=1 -> out_mask=9'b0_0101_0100 (0x054), out_cand=0x1AB, out_empty_cnt=6, out_dup=0, out_all_set=0, out_valid on the cycle after the 9th beat.
- N=9, stream 1..9 in any order -> out_mask=0x1FF, out_all_set=1, out_cand=0; then a second group streamed back-to-back -> starts accepting the cycle after the handshake.
- N=9, stream 4,2,4,2,0,0,0,0,0 -> out_dup=1, out_dup_value=4, out_mask=0x00A, out_all_set=0.
- N=9, a value of 12 in beat 3 -> out_range_err=1 and mask unaffected; with out_ready=0 for 5 cycles -> outputs stable, in_ready=0, extra in_valid beats not consumed.
- clear asserted after 4 beats, then a full group of 9,8,...,1 -> the result reflects only the new group (mask 0x1FF, empty_cnt 0); clear on the handshake cycle drops the result.
- N=16 and N=4 builds: all values 1..N -> mask all ones; value N+1 -> range_err; async rst_n pulse mid-group -> out_valid=0 and in_ready=1 after release.
